// File: rtl/md_controller.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, runs MULT/DIV for a
// fixed latency, and commits results unless the launching instruction is squashed.
module md_controller #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        cancel,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Launch protocol: start is a one-cycle strobe sampled only in IDLE; cancel
  // in the same cycle suppresses it, and cancel during RUN aborts without commit.
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      state, next_state;
  logic [3:0]  count, next_count;
  logic [31:0] pending_hi, pending_lo;
  logic [31:0] res_hi, res_lo;
  logic        launch, commit, mt_hi_wr, mt_lo_wr;

  logic [63:0]        ext_a, ext_b, prod;
  logic signed [31:0] s_a, s_b, s_q, s_r;
  logic [31:0]        u_q, u_r;

  always_comb begin
    next_state = state;
    next_count = count;
    launch     = 1'b0;
    commit     = 1'b0;
    mt_hi_wr   = 1'b0;
    mt_lo_wr   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !cancel) begin
          if (op <= 3'd3) begin
            launch     = 1'b1;
            next_state = RUN;
            next_count = op[1] ? DIV_N : MULT_N;
          end else if (op == 3'd4) begin
            mt_hi_wr = 1'b1;
          end else if (op == 3'd5) begin
            mt_lo_wr = 1'b1;
          end
        end
      end
      RUN: begin
        if (cancel) begin
          next_state = IDLE;
          next_count = 4'd0;
        end else if (count == 4'd1) begin
          commit     = 1'b1;
          next_state = IDLE;
          next_count = 4'd0;
        end else begin
          next_count = count - 4'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_count = 4'd0;
      end
    endcase
  end

  // Result is computed at launch from the live operands and held until commit.
  always_comb begin
    ext_a = op[0] ? {32'd0, rs_data} : {{32{rs_data[31]}}, rs_data};
    ext_b = op[0] ? {32'd0, rt_data} : {{32{rt_data[31]}}, rt_data};
    prod  = ext_a * ext_b;
    s_a   = $signed(rs_data);
    s_b   = $signed(rt_data);
    s_q   = s_a / s_b;
    s_r   = s_a % s_b;
    u_q   = rs_data / rt_data;
    u_r   = rs_data % rt_data;
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    if (op[1]) begin
      if (rt_data == 32'd0) begin
        res_hi = rs_data;
        res_lo = 32'hFFFF_FFFF;
      end else if (!op[0] && rs_data == 32'h8000_0000 && rt_data == 32'hFFFF_FFFF) begin
        res_hi = 32'd0;
        res_lo = 32'h8000_0000;
      end else if (!op[0]) begin
        res_hi = s_r;
        res_lo = s_q;
      end else begin
        res_hi = u_r;
        res_lo = u_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      count      <= 4'd0;
      pending_hi <= 32'd0;
      pending_lo <= 32'd0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      done       <= 1'b0;
    end else begin
      state <= next_state;
      count <= next_count;
      done  <= commit;
      if (launch) begin
        pending_hi <= res_hi;
        pending_lo <= res_lo;
      end
      if (commit) begin
        hi <= pending_hi;
        lo <= pending_lo;
      end else begin
        if (mt_hi_wr) hi <= rs_data;
        if (mt_lo_wr) lo <= rs_data;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: tb/tb_md_controller.sv
// Self-checking bench for md_controller: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_md_controller;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk, reset_n, start, cancel, busy, done;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data, hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;
  logic [63:0] exp_q[$];

  md_controller #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .cancel(cancel),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: returns {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = 64'd0;
    case (o)
      3'd0: res = sa * sb;
      3'd1: res = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    int exp_n;
    logic [63:0] e;
    exp_q.push_back(model(o, a, b));
    exp_n = (o < 3'd2) ? MULT_N : DIV_N;
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0; rs_data = $urandom; rt_data = $urandom;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      checks++;
      if (done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL %s busy-phase: done=%b hi=%h lo=%h required done=0 hi=%h lo=%h", name, done, hi, lo, m_hi, m_lo);
      end
      n++;
      @(negedge clk);
    end
    e = exp_q.pop_front();
    m_hi = e[63:32];
    m_lo = e[31:0];
    checks++;
    if (n != exp_n) begin
      errors++;
      $display("FAIL %s busy-cycles: got %0d required %0d", name, n, exp_n);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done-pulse: got %b required 1", name, done);
    end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++;
      $display("FAIL %s result: hi=%h lo=%h required hi=%h lo=%h", name, hi, lo, m_hi, m_lo);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after-commit: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic do_mt(input logic [2:0] o, input logic [31:0] a);
    @(negedge clk);
    start = 1'b1; op = o; rs_data = a; rt_data = $urandom;
    @(negedge clk);
    start = 1'b0;
    if (o == 3'd4) m_hi = a;
    if (o == 3'd5) m_lo = a;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mt_op%0d: hi=%h lo=%h busy=%b done=%b required hi=%h lo=%h 0 0", o, hi, lo, busy, done, m_hi, m_lo);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; cancel = 1'b0; op = 3'd0; rs_data = 32'd0; rt_data = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL reset_release: busy=%b hi=%h lo=%h required 0", busy, hi, lo);
    end
  endtask

  task automatic test_directed();
    run_md(3'd0, 32'hFFFF_FFFE, 32'd3, "mult_neg");
    run_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    run_md(3'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
    run_md(3'd3, 32'd7, 32'd0, "divu_zero");
    run_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_md(3'd2, 32'd5, 32'd0, "div_zero");
  endtask

  task automatic test_cancel();
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_data = 32'd100; rt_data = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    for (int i = 0; i < DIV_N; i++) begin
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL cancel_run cyc%0d: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", i, busy, done, hi, lo, m_hi, m_lo);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_cancel();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; op = (k == 0) ? 3'd2 : 3'(3 + k); rs_data = $urandom; rt_data = $urandom;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      repeat (2) begin
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
          errors++;
          $display("FAIL start_cancel op%0d: busy=%b done=%b hi=%h lo=%h required 0 0 %h %h", op, busy, done, hi, lo, m_hi, m_lo);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_mt_back_to_back();
    @(negedge clk);
    start = 1'b1; op = 3'd4; rs_data = 32'h1234_5678;
    @(negedge clk);
    m_hi = 32'h1234_5678;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi_b2b: hi=%h lo=%h busy=%b required %h %h 0", hi, lo, busy, m_hi, m_lo);
    end
    op = 3'd5; rs_data = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    m_lo = 32'h9ABC_DEF0;
    checks++;
    if (hi !== m_hi || lo !== m_lo || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL mtlo_b2b: hi=%h lo=%h busy=%b done=%b required %h %h 0 0", hi, lo, busy, done, m_hi, m_lo);
    end
  endtask

  task automatic test_reserved();
    for (int k = 6; k < 8; k++) begin
      @(negedge clk);
      start = 1'b1; op = 3'(k); rs_data = $urandom; rt_data = $urandom;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || hi !== m_hi || lo !== m_lo) begin
        errors++;
        $display("FAIL reserved op%0d: busy=%b done=%b hi=%h lo=%h", k, busy, done, hi, lo);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    start = 1'b1; op = 3'd0; rs_data = 32'd1234; rt_data = 32'd5678;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
    end
    m_hi = 32'd0; m_lo = 32'd0;
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    run_md(3'd0, 32'd1234, 32'd5678, "mult_after_reset");
  endtask

  task automatic test_random();
    logic [2:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 9));
        default: ;
      endcase
      if (o <= 3'd3) run_md(o, a, b, "random");
      else if (o <= 3'd5) do_mt(o, a);
      else test_reserved();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_cancel();
    test_start_cancel();
    test_mt_back_to_back();
    test_reserved();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
